// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED sequencer: mode encoding, debouncer
// state encoding and default timing values.
package led_ctrl_pkg;

    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_FLASH = 1'b1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } deb_state_t;

    localparam int unsigned DEF_LIM0       = 12_500_000;
    localparam int unsigned DEF_LIM1       = 25_000_000;
    localparam int unsigned DEF_LIM2       = 50_000_000;
    localparam int unsigned DEF_LIM3       = 100_000_000;
    localparam int unsigned DEF_DEB_CYCLES = 1_000_000;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle of the LED sequencer.
// master: drives i_enable, i_sw_speed, i_btn_mode; reads LED outputs.
// slave : the sequencer; reads controls, drives o_mux_sel, o_shift_leds,
//         o_flash_leds, o_tick.
interface led_seq_ctrl_if #(
    parameter int N_LEDS = 4
);

    logic              i_enable;
    logic [1:0]        i_sw_speed;
    logic              i_btn_mode;
    logic              o_mux_sel;
    logic [N_LEDS-1:0] o_shift_leds;
    logic [N_LEDS-1:0] o_flash_leds;
    logic              o_tick;

    modport master (
        output i_enable,
        output i_sw_speed,
        output i_btn_mode,
        input  o_mux_sel,
        input  o_shift_leds,
        input  o_flash_leds,
        input  o_tick
    );

    modport slave (
        input  i_enable,
        input  i_sw_speed,
        input  i_btn_mode,
        output o_mux_sel,
        output o_shift_leds,
        output o_flash_leds,
        output o_tick
    );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce FSM with stability counter.
// Ports: i_clk, i_reset (sync, active high), i_btn (raw), o_level
//        (debounced level), o_rise (one-cycle debounced press pulse).
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DONE_CNT = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [1:0]    fill_q;
    logic          armed_q;
    deb_state_t    state_q;
    deb_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          done;

    assign done = (cnt_q == DONE_CNT);

    // armed_q: a press only counts once the synchronizer has shown the
    // button released, so a button held through reset never toggles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_rise  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (sync2_q) state_d = CHK_HI;
            end
            CHK_HI: begin
                if (!sync2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    o_rise  = armed_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!sync2_q) state_d = CHK_LO;
            end
            CHK_LO: begin
                if (sync2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_level = (state_q == STABLE_HI) || (state_q == CHK_LO);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: speed-selectable prescaler, rotating and blinking
// patterns, and a button-toggled display mode.
// Ports: i_clk, i_reset (sync, active high), bus (led_seq_ctrl_if.slave).
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int          N_LEDS     = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned LIM0       = DEF_LIM0,
    parameter int unsigned LIM1       = DEF_LIM1,
    parameter int unsigned LIM2       = DEF_LIM2,
    parameter int unsigned LIM3       = DEF_LIM3,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic           i_clk,
    input  logic           i_reset,
    led_seq_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LIM0_M1 = CNT_W'(LIM0 - 1);
    localparam logic [CNT_W-1:0] LIM1_M1 = CNT_W'(LIM1 - 1);
    localparam logic [CNT_W-1:0] LIM2_M1 = CNT_W'(LIM2 - 1);
    localparam logic [CNT_W-1:0] LIM3_M1 = CNT_W'(LIM3 - 1);
    localparam logic [N_LEDS-1:0] SHIFT_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  lim_m1;
    logic              tick_q;
    logic              mode_q;
    logic [N_LEDS-1:0] shift_q;
    logic [N_LEDS-1:0] flash_q;
    logic              wrap;
    logic              deb_level;
    logic              deb_rise;
    logic              toggle;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (bus.i_btn_mode),
        .o_level (deb_level),
        .o_rise  (deb_rise)
    );

    // A rise is only meaningful while the debounced level is still low.
    assign toggle = deb_rise && !deb_level;

    always_comb begin
        lim_m1 = LIM0_M1;
        unique case (bus.i_sw_speed)
            2'd0: lim_m1 = LIM0_M1;
            2'd1: lim_m1 = LIM1_M1;
            2'd2: lim_m1 = LIM2_M1;
            2'd3: lim_m1 = LIM3_M1;
        endcase
    end

    // >= rather than == so a drop to a shorter period wraps at once.
    assign wrap = (cnt_q >= lim_m1);

    // o_tick is registered: it is high in the cycle after the count
    // reaches the limit. Patterns step on the edge that ends that cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            mode_q  <= MODE_SHIFT;
            shift_q <= SHIFT_INIT;
            flash_q <= '0;
        end else if (toggle) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            mode_q  <= ~mode_q;
            shift_q <= SHIFT_INIT;
            flash_q <= '0;
        end else begin
            if (bus.i_enable) begin
                cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
                tick_q <= wrap;
            end else begin
                tick_q <= 1'b0;
            end
            if (tick_q) begin
                shift_q <= {shift_q[N_LEDS-2:0], shift_q[N_LEDS-1]};
                flash_q <= ~flash_q;
            end
        end
    end

    assign bus.o_mux_sel    = mode_q;
    assign bus.o_shift_leds = shift_q;
    assign bus.o_flash_leds = flash_q;
    assign bus.o_tick       = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with short timing parameters.
// Scenario tasks push expected tick/mode events and compare on arrival.
module tb_led_seq_ctrl;
    import led_ctrl_pkg::*;

    localparam int N = 4;

    typedef struct {
        int           cyc;
        logic [N-1:0] shift;
        logic [N-1:0] flash;
    } tick_ev_t;

    typedef struct {
        int   cyc;
        logic val;
    } mode_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tick_ev_t tq[$];
    mode_ev_t mq[$];

    always #5 clk = ~clk;

    led_seq_ctrl_if #(.N_LEDS(N)) bus ();

    led_seq_ctrl #(
        .N_LEDS     (N),
        .CNT_W      (8),
        .LIM0       (4),
        .LIM1       (6),
        .LIM2       (8),
        .LIM3       (10),
        .DEB_CYCLES (3)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [N-1:0] rot_k(input int k);
        logic [N-1:0] v;
        v = 1;
        for (int i = 0; i < k % N; i++) v = {v[N-2:0], v[N-1]};
        return v;
    endfunction

    function automatic logic [N-1:0] flash_k(input int k);
        return (k % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
    endfunction

    task automatic push_tick(input int cyc, input int k);
        tick_ev_t e;
        e.cyc = cyc;
        e.shift = rot_k(k);
        e.flash = flash_k(k);
        tq.push_back(e);
    endtask

    task automatic push_mode(input int cyc, input logic v);
        mode_ev_t e;
        e.cyc = cyc;
        e.val = v;
        mq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic btn);
        rst = 1'b1;
        bus.i_btn_mode = btn;
        step();
        step();
        rst = 1'b0;
        tq.delete();
        mq.delete();
    endtask

    task automatic test_reset();
        bus.i_enable = 1'b1;
        bus.i_sw_speed = 2'd3;
        bus.i_btn_mode = 1'b1;
        rst = 1'b1;
        step();
        step();
        step();
        checks += 5;
        if (bus.o_mux_sel !== MODE_SHIFT) begin
            errors++;
            $display("FAIL reset_mux got %b exp 0", bus.o_mux_sel);
        end
        if (bus.o_shift_leds !== 4'b0001) begin
            errors++;
            $display("FAIL reset_shift got %b exp 0001", bus.o_shift_leds);
        end
        if (bus.o_flash_leds !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flash got %b exp 0000", bus.o_flash_leds);
        end
        if (bus.o_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got %b exp 0", bus.o_tick);
        end
        if (dut.u_deb.state_q !== STABLE_LO) begin
            errors++;
            $display("FAIL reset_deb got %0d exp %0d",
                     dut.u_deb.state_q, STABLE_LO);
        end
    endtask

    task automatic test_shift();
        tick_ev_t pend;
        bit has_pend = 0;
        bus.i_enable = 1'b1;
        bus.i_sw_speed = 2'd0;
        apply_reset(1'b0);
        for (int k = 1; k <= 4; k++) push_tick(4 * k, k);
        for (int c = 1; c <= 18; c++) begin
            step();
            if (has_pend) begin
                checks++;
                has_pend = 0;
                if (bus.o_shift_leds !== pend.shift ||
                    bus.o_flash_leds !== pend.flash) begin
                    errors++;
                    $display("FAIL shift_pat cyc=%0d got %b/%b exp %b/%b", c,
                             bus.o_shift_leds, bus.o_flash_leds,
                             pend.shift, pend.flash);
                end
            end
            if (bus.o_tick === 1'b1) begin
                checks++;
                if (tq.size() == 0) begin
                    errors++;
                    $display("FAIL shift_tick extra at cyc=%0d exp none", c);
                end else begin
                    pend = tq.pop_front();
                    has_pend = 1;
                    if (pend.cyc != c) begin
                        errors++;
                        $display("FAIL shift_tick got cyc=%0d exp %0d",
                                 c, pend.cyc);
                    end
                end
            end
        end
        checks++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL shift_missing got %0d left exp 0", tq.size());
        end
    endtask

    task automatic test_speed();
        tick_ev_t pend;
        bit has_pend = 0;
        bus.i_enable = 1'b1;
        bus.i_sw_speed = 2'd1;
        apply_reset(1'b0);
        push_tick(5, 1);
        push_tick(9, 2);
        push_tick(13, 3);
        push_tick(19, 4);
        push_tick(25, 5);
        push_tick(29, 6);
        push_tick(33, 7);
        for (int c = 1; c <= 35; c++) begin
            if (c == 5) bus.i_sw_speed = 2'd0;
            if (c == 14) bus.i_sw_speed = 2'd1;
            if (c == 25) bus.i_sw_speed = 2'd0;
            step();
            if (has_pend) begin
                checks++;
                has_pend = 0;
                if (bus.o_shift_leds !== pend.shift ||
                    bus.o_flash_leds !== pend.flash) begin
                    errors++;
                    $display("FAIL speed_pat cyc=%0d got %b/%b exp %b/%b", c,
                             bus.o_shift_leds, bus.o_flash_leds,
                             pend.shift, pend.flash);
                end
            end
            if (bus.o_tick === 1'b1) begin
                checks++;
                if (tq.size() == 0) begin
                    errors++;
                    $display("FAIL speed_tick extra at cyc=%0d exp none", c);
                end else begin
                    pend = tq.pop_front();
                    has_pend = 1;
                    if (pend.cyc != c) begin
                        errors++;
                        $display("FAIL speed_tick got cyc=%0d exp %0d",
                                 c, pend.cyc);
                    end
                end
            end
        end
        checks++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL speed_missing got %0d left exp 0", tq.size());
        end
    endtask

    task automatic test_enable();
        tick_ev_t pend;
        bit has_pend = 0;
        bus.i_enable = 1'b1;
        bus.i_sw_speed = 2'd0;
        apply_reset(1'b0);
        push_tick(4, 1);
        push_tick(18, 2);
        push_tick(22, 3);
        for (int c = 1; c <= 24; c++) begin
            if (c == 7) bus.i_enable = 1'b0;
            if (c == 17) bus.i_enable = 1'b1;
            step();
            if (c == 16) begin
                checks++;
                if (bus.o_shift_leds !== 4'b0010 ||
                    bus.o_flash_leds !== 4'b1111) begin
                    errors++;
                    $display("FAIL enable_frozen got %b/%b exp 0010/1111",
                             bus.o_shift_leds, bus.o_flash_leds);
                end
            end
            if (has_pend) begin
                checks++;
                has_pend = 0;
                if (bus.o_shift_leds !== pend.shift ||
                    bus.o_flash_leds !== pend.flash) begin
                    errors++;
                    $display("FAIL enable_pat cyc=%0d got %b/%b exp %b/%b", c,
                             bus.o_shift_leds, bus.o_flash_leds,
                             pend.shift, pend.flash);
                end
            end
            if (bus.o_tick === 1'b1) begin
                checks++;
                if (tq.size() == 0) begin
                    errors++;
                    $display("FAIL enable_tick extra at cyc=%0d exp none", c);
                end else begin
                    pend = tq.pop_front();
                    has_pend = 1;
                    if (pend.cyc != c) begin
                        errors++;
                        $display("FAIL enable_tick got cyc=%0d exp %0d",
                                 c, pend.cyc);
                    end
                end
            end
        end
        checks++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL enable_missing got %0d left exp 0", tq.size());
        end
    endtask

    task automatic test_mode();
        mode_ev_t mev;
        logic prev = MODE_SHIFT;
        bus.i_enable = 1'b0;
        bus.i_sw_speed = 2'd0;
        apply_reset(1'b0);
        push_mode(11, 1'b1);
        push_mode(31, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (c == 6) bus.i_btn_mode = 1'b1;
            if (c == 16) bus.i_btn_mode = 1'b0;
            if (c == 26) bus.i_btn_mode = 1'b1;
            if (c == 36) bus.i_btn_mode = 1'b0;
            step();
            if (bus.o_mux_sel !== prev) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL mode_extra cyc=%0d got %b", c,
                             bus.o_mux_sel);
                end else begin
                    mev = mq.pop_front();
                    if (mev.cyc != c || bus.o_mux_sel !== mev.val) begin
                        errors++;
                        $display("FAIL mode_change got cyc=%0d val=%b exp cyc=%0d val=%b",
                                 c, bus.o_mux_sel, mev.cyc, mev.val);
                    end
                end
                prev = bus.o_mux_sel;
            end
        end
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL mode_missing got %0d left exp 0", mq.size());
        end
    endtask

    task automatic test_bounce();
        bus.i_enable = 1'b0;
        apply_reset(1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (c == 6) bus.i_btn_mode = 1'b1;
            if (c == 7) bus.i_btn_mode = 1'b0;
            if (c == 8) bus.i_btn_mode = 1'b1;
            if (c == 9) bus.i_btn_mode = 1'b0;
            step();
            if (c == 8) begin
                checks++;
                if (dut.u_deb.state_q !== CHK_HI) begin
                    errors++;
                    $display("FAIL bounce_chk got %0d exp %0d",
                             dut.u_deb.state_q, CHK_HI);
                end
            end
            if (bus.o_mux_sel !== MODE_SHIFT) begin
                checks++;
                errors++;
                $display("FAIL bounce_mux cyc=%0d got %b exp 0", c,
                         bus.o_mux_sel);
            end
        end
        checks += 2;
        if (dut.u_deb.state_q !== STABLE_LO) begin
            errors++;
            $display("FAIL bounce_state got %0d exp %0d",
                     dut.u_deb.state_q, STABLE_LO);
        end
        if (bus.o_mux_sel !== MODE_SHIFT) begin
            errors++;
            $display("FAIL bounce_final got %b exp 0", bus.o_mux_sel);
        end
    endtask

    task automatic test_toggle_tick();
        tick_ev_t pend;
        mode_ev_t mev;
        bit has_pend = 0;
        logic prev = MODE_SHIFT;
        bus.i_enable = 1'b1;
        bus.i_sw_speed = 2'd0;
        apply_reset(1'b0);
        push_tick(4, 1);
        push_tick(8, 2);
        push_tick(12, 0);
        push_tick(17, 1);
        push_tick(21, 2);
        push_mode(13, 1'b1);
        for (int c = 1; c <= 24; c++) begin
            if (c == 8) bus.i_btn_mode = 1'b1;
            if (c == 21) bus.i_btn_mode = 1'b0;
            step();
            if (has_pend) begin
                checks++;
                has_pend = 0;
                if (bus.o_shift_leds !== pend.shift ||
                    bus.o_flash_leds !== pend.flash) begin
                    errors++;
                    $display("FAIL toggle_pat cyc=%0d got %b/%b exp %b/%b", c,
                             bus.o_shift_leds, bus.o_flash_leds,
                             pend.shift, pend.flash);
                end
            end
            if (bus.o_tick === 1'b1) begin
                checks++;
                if (tq.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_tick extra at cyc=%0d exp none", c);
                end else begin
                    pend = tq.pop_front();
                    has_pend = 1;
                    if (pend.cyc != c) begin
                        errors++;
                        $display("FAIL toggle_tick got cyc=%0d exp %0d",
                                 c, pend.cyc);
                    end
                end
            end
            if (bus.o_mux_sel !== prev) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_mode_extra cyc=%0d got %b", c,
                             bus.o_mux_sel);
                end else begin
                    mev = mq.pop_front();
                    if (mev.cyc != c || bus.o_mux_sel !== mev.val) begin
                        errors++;
                        $display("FAIL toggle_mode got cyc=%0d val=%b exp cyc=%0d val=%b",
                                 c, bus.o_mux_sel, mev.cyc, mev.val);
                    end
                end
                prev = bus.o_mux_sel;
            end
        end
        checks++;
        if (tq.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL toggle_missing got %0d/%0d left exp 0/0",
                     tq.size(), mq.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (bus.o_mux_sel !== MODE_FLASH) begin
            errors++;
            $display("FAIL mid_pre_mux got %b exp 1", bus.o_mux_sel);
        end
        bus.i_btn_mode = 1'b1;
        step();
        step();
        step();
        checks++;
        if (dut.u_deb.state_q !== CHK_HI) begin
            errors++;
            $display("FAIL mid_chk got %0d exp %0d",
                     dut.u_deb.state_q, CHK_HI);
        end
        rst = 1'b1;
        step();
        checks += 5;
        if (bus.o_mux_sel !== MODE_SHIFT) begin
            errors++;
            $display("FAIL mid_mux got %b exp 0", bus.o_mux_sel);
        end
        if (bus.o_shift_leds !== 4'b0001) begin
            errors++;
            $display("FAIL mid_shift got %b exp 0001", bus.o_shift_leds);
        end
        if (bus.o_flash_leds !== 4'b0000) begin
            errors++;
            $display("FAIL mid_flash got %b exp 0000", bus.o_flash_leds);
        end
        if (bus.o_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_tick got %b exp 0", bus.o_tick);
        end
        if (dut.u_deb.state_q !== STABLE_LO) begin
            errors++;
            $display("FAIL mid_deb got %0d exp %0d",
                     dut.u_deb.state_q, STABLE_LO);
        end
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.o_mux_sel !== MODE_SHIFT) begin
                checks++;
                errors++;
                $display("FAIL held_mux cyc=%0d got %b exp 0", c,
                         bus.o_mux_sel);
            end
        end
        checks++;
        if (dut.u_deb.state_q !== STABLE_HI) begin
            errors++;
            $display("FAIL held_state got %0d exp %0d",
                     dut.u_deb.state_q, STABLE_HI);
        end
        bus.i_btn_mode = 1'b0;
    endtask

    initial begin
        bus.i_enable = 1'b0;
        bus.i_sw_speed = 2'd0;
        bus.i_btn_mode = 1'b0;
        test_reset();
        test_shift();
        test_speed();
        test_enable();
        test_mode();
        test_bounce();
        test_toggle_tick();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
